// File: rtl/spi_sd_responder_if.sv
// ----------------------------------------------------------------------------
// spi_sd_responder_if
// Bundles the SPI pins, the block read port and the command status outputs of
// the SPI-mode SD card responder.
//   spi_ssn/spi_sck/spi_mosi : SPI inputs from the host (mode 3, MSB first)
//   spi_miso                 : SPI response data to the host
//   rreq/raddr/rindex/rdata  : block read port (rdata sampled 2 clk after rreq)
//   cmd_valid/cmd_index/cmd_arg/in_idle : decoded command status
// Modports: master = host/bench side, slave = responder side.
// ----------------------------------------------------------------------------
interface spi_sd_responder_if;
  logic        spi_ssn;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic        rreq;
  logic [31:0] raddr;
  logic [8:0]  rindex;
  logic [7:0]  rdata;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        in_idle;

  modport master (
    output spi_ssn, spi_sck, spi_mosi, rdata,
    input  spi_miso, rreq, raddr, rindex, cmd_valid, cmd_index, cmd_arg, in_idle
  );

  modport slave (
    input  spi_ssn, spi_sck, spi_mosi, rdata,
    output spi_miso, rreq, raddr, rindex, cmd_valid, cmd_index, cmd_arg, in_idle
  );
endinterface

// File: rtl/spi_sd_responder.sv
// ----------------------------------------------------------------------------
// spi_sd_responder
// SPI-mode SD card emulator (target side). Oversamples ssn/sck/mosi on clk,
// decodes 6-byte command frames, returns R1/R7/R3 responses and serves CMD17
// single-block reads (0xFE token + 512 bytes from the read port + 2 CRC bytes).
// Ports:
//   clk  : system clock, at least 8x spi_sck
//   rstn : synchronous active-low reset
//   bus  : spi_sd_responder_if.slave (SPI pins, read port, command status)
// Parameters:
//   INIT_RETRIES : ACMD41 calls answered busy (0x01) before ready (0x00)
//   DATA_DELAY   : 0xFF bytes between the CMD17 R1 and the data token (0..255)
// Build option:
//   SD_RESPONDER_CRC16_EN : when defined the block CRC is CRC16-CCITT
//   (poly 0x1021, init 0x0000); otherwise the CRC bytes are 0xFF 0xFF.
// ----------------------------------------------------------------------------
module spi_sd_responder #(
  parameter int unsigned INIT_RETRIES = 1,
  parameter int unsigned DATA_DELAY   = 2
) (
  input logic             clk,
  input logic             rstn,
  spi_sd_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_NCR   = 3'd2,
    ST_RSP   = 3'd3,
    ST_DLY   = 3'd4,
    ST_TOKEN = 3'd5,
    ST_DATA  = 3'd6,
    ST_CRC   = 3'd7
  } state_e;

  localparam logic [7:0] RETRIES_C = INIT_RETRIES[7:0];
  localparam logic [7:0] DELAY_C   = DATA_DELAY[7:0];

`ifdef SD_RESPONDER_CRC16_EN
  // Bit-serial CRC16-CCITT update with one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction
`endif

  // Synchronizer stages (m = metastable stage, s = synchronized value)
  logic ssn_m_q, ssn_s_q, sck_m_q, sck_s_q, sck_p_q, mosi_m_q, mosi_s_q;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  idx_sh_q, idx_sh_d;
  logic [31:0] arg_sh_q, arg_sh_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        is_acmd_q, is_acmd_d;
  logic        acmd_pend_q, acmd_pend_d;
  logic        in_idle_q, in_idle_d;
  logic [7:0]  acmd_cnt_q, acmd_cnt_d;
  logic [31:0] rsp_buf_q, rsp_buf_d;
  logic [2:0]  rsp_left_q, rsp_left_d;
  logic        go_data_q, go_data_d;
  logic [7:0]  dly_cnt_q, dly_cnt_d;
  logic [8:0]  data_cnt_q, data_cnt_d;
  logic [7:0]  data_buf_q, data_buf_d;
  logic        crc_cnt_q, crc_cnt_d;
  logic        rreq_q, rreq_d;
  logic        rreq_p_q, rreq_p_d;
  logic [31:0] raddr_q, raddr_d;
  logic [8:0]  rindex_q, rindex_d;
`ifdef SD_RESPONDER_CRC16_EN
  logic [15:0] crc_q, crc_d;
`endif

  logic       sck_rise, sck_fall;
  logic [7:0] rx_byte;
  logic [7:0] r1;

  assign sck_rise = ~ssn_s_q &  sck_s_q & ~sck_p_q;
  assign sck_fall = ~ssn_s_q & ~sck_s_q &  sck_p_q;
  assign rx_byte  = {rx_q, mosi_s_q};

  // Two-stage synchronizers for the asynchronous SPI pins plus sck history
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ssn_m_q  <= 1'b1;
      ssn_s_q  <= 1'b1;
      sck_m_q  <= 1'b1;
      sck_s_q  <= 1'b1;
      sck_p_q  <= 1'b1;
      mosi_m_q <= 1'b1;
      mosi_s_q <= 1'b1;
    end else begin
      ssn_m_q  <= bus.spi_ssn;
      ssn_s_q  <= ssn_m_q;
      sck_m_q  <= bus.spi_sck;
      sck_s_q  <= sck_m_q;
      sck_p_q  <= sck_s_q;
      mosi_m_q <= bus.spi_mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  // Bit engine, byte-level FSM and response/read-port sequencing
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    frame_cnt_d = frame_cnt_q;
    idx_sh_d    = idx_sh_q;
    arg_sh_d    = arg_sh_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    is_acmd_d   = is_acmd_q;
    acmd_pend_d = acmd_pend_q;
    in_idle_d   = in_idle_q;
    acmd_cnt_d  = acmd_cnt_q;
    rsp_buf_d   = rsp_buf_q;
    rsp_left_d  = rsp_left_q;
    go_data_d   = go_data_q;
    dly_cnt_d   = dly_cnt_q;
    data_cnt_d  = data_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    rreq_d      = 1'b0;
    rreq_p_d    = rreq_q;
    raddr_d     = raddr_q;
    rindex_d    = rindex_q;
    r1          = 8'h00;
`ifdef SD_RESPONDER_CRC16_EN
    crc_d       = crc_q;
`endif
    // Read data lands two cycles after the request pulse
    if (rreq_p_q) begin
      data_buf_d = bus.rdata;
    end else begin
      data_buf_d = data_buf_q;
    end

    if (ssn_s_q) begin
      bitcnt_d    = 3'd0;
      tx_d        = 8'hFF;
      miso_d      = 1'b1;
      state_d     = ST_IDLE;
      frame_cnt_d = 3'd0;
      rsp_left_d  = 3'd0;
      go_data_d   = 1'b0;
    end else begin
      // ~bitcnt selects bit 7-bitcnt: MSB first
      if (sck_fall) begin
        miso_d = tx_q[~bitcnt_q];
      end else begin
        miso_d = miso_q;
      end
      if (sck_rise) begin
        rx_d     = rx_byte[6:0];
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          // Byte boundary: act on the received byte and load the next tx byte
          case (state_q)
            ST_IDLE: begin
              tx_d = 8'hFF;
              if (rx_byte[7:6] == 2'b01) begin
                idx_sh_d    = rx_byte[5:0];
                frame_cnt_d = 3'd1;
                state_d     = ST_CMD;
              end else begin
                state_d = ST_IDLE;
              end
            end
            ST_CMD: begin
              tx_d = 8'hFF;
              if (frame_cnt_q == 3'd5) begin
                // CRC byte ignored; publish the frame
                cmd_valid_d = 1'b1;
                cmd_index_d = idx_sh_q;
                cmd_arg_d   = arg_sh_q;
                is_acmd_d   = acmd_pend_q;
                acmd_pend_d = 1'b0;
                state_d     = ST_NCR;
              end else begin
                arg_sh_d    = {arg_sh_q[23:0], rx_byte};
                frame_cnt_d = frame_cnt_q + 3'd1;
              end
            end
            ST_NCR: begin
              rsp_buf_d  = 32'h0000_0000;
              rsp_left_d = 3'd0;
              go_data_d  = 1'b0;
              if (is_acmd_q && (cmd_index_q == 6'd41)) begin
                if (acmd_cnt_q < RETRIES_C) begin
                  acmd_cnt_d = acmd_cnt_q + 8'd1;
                  r1         = 8'h01;
                end else begin
                  in_idle_d = 1'b0;
                  r1        = 8'h00;
                end
              end else begin
                case (cmd_index_q)
                  6'd0: begin
                    in_idle_d = 1'b1;
                    r1        = 8'h01;
                  end
                  6'd8: begin
                    r1         = {7'd0, in_idle_q};
                    rsp_buf_d  = {24'h00_0001, cmd_arg_q[7:0]};
                    rsp_left_d = 3'd4;
                  end
                  6'd58: begin
                    r1         = {7'd0, in_idle_q};
                    rsp_buf_d  = 32'hC0FF_8000;
                    rsp_left_d = 3'd4;
                  end
                  6'd55: begin
                    r1          = {7'd0, in_idle_q};
                    acmd_pend_d = 1'b1;
                  end
                  6'd16: begin
                    r1 = {7'd0, in_idle_q};
                  end
                  6'd17: begin
                    if (in_idle_q) begin
                      r1 = 8'h05;
                    end else begin
                      r1        = 8'h00;
                      raddr_d   = cmd_arg_q;
                      rindex_d  = 9'd0;
                      go_data_d = 1'b1;
                    end
                  end
                  default: begin
                    r1 = {5'd0, 1'b1, 1'b0, in_idle_q};
                  end
                endcase
              end
              tx_d    = r1;
              state_d = ST_RSP;
            end
            ST_RSP: begin
              if (rsp_left_q != 3'd0) begin
                tx_d       = rsp_buf_q[31:24];
                rsp_buf_d  = {rsp_buf_q[23:0], 8'h00};
                rsp_left_d = rsp_left_q - 3'd1;
              end else if (go_data_q) begin
                go_data_d = 1'b0;
                if (DELAY_C == 8'd0) begin
                  tx_d     = 8'hFE;
                  rreq_d   = 1'b1;
                  rindex_d = 9'd0;
                  state_d  = ST_TOKEN;
                end else begin
                  tx_d      = 8'hFF;
                  dly_cnt_d = 8'd1;
                  state_d   = ST_DLY;
                end
              end else begin
                tx_d    = 8'hFF;
                state_d = ST_IDLE;
              end
            end
            ST_DLY: begin
              if (dly_cnt_q == DELAY_C) begin
                tx_d     = 8'hFE;
                rreq_d   = 1'b1;
                rindex_d = 9'd0;
                state_d  = ST_TOKEN;
              end else begin
                tx_d      = 8'hFF;
                dly_cnt_d = dly_cnt_q + 8'd1;
              end
            end
            ST_TOKEN: begin
              // Byte 0 was fetched while the token was sent; prefetch byte 1
              tx_d       = data_buf_q;
              data_cnt_d = 9'd0;
              rreq_d     = 1'b1;
              rindex_d   = 9'd1;
              state_d    = ST_DATA;
`ifdef SD_RESPONDER_CRC16_EN
              crc_d      = crc16_byte(16'h0000, data_buf_q);
`endif
            end
            ST_DATA: begin
              if (data_cnt_q == 9'd511) begin
`ifdef SD_RESPONDER_CRC16_EN
                tx_d = crc_q[15:8];
`else
                tx_d = 8'hFF;
`endif
                crc_cnt_d = 1'b0;
                state_d   = ST_CRC;
              end else begin
                tx_d       = data_buf_q;
                data_cnt_d = data_cnt_q + 9'd1;
`ifdef SD_RESPONDER_CRC16_EN
                crc_d      = crc16_byte(crc_q, data_buf_q);
`endif
                // Byte data_cnt+1 goes out now; prefetch data_cnt+2 if it exists
                if (data_cnt_q != 9'd510) begin
                  rreq_d   = 1'b1;
                  rindex_d = data_cnt_q + 9'd2;
                end else begin
                  rreq_d = 1'b0;
                end
              end
            end
            ST_CRC: begin
              if (!crc_cnt_q) begin
`ifdef SD_RESPONDER_CRC16_EN
                tx_d = crc_q[7:0];
`else
                tx_d = 8'hFF;
`endif
                crc_cnt_d = 1'b1;
              end else begin
                tx_d    = 8'hFF;
                state_d = ST_IDLE;
              end
            end
            default: begin
              tx_d    = 8'hFF;
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = state_q;
        end
      end else begin
        bitcnt_d = bitcnt_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'hFF;
      miso_q      <= 1'b1;
      frame_cnt_q <= 3'd0;
      idx_sh_q    <= 6'd0;
      arg_sh_q    <= 32'd0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      is_acmd_q   <= 1'b0;
      acmd_pend_q <= 1'b0;
      in_idle_q   <= 1'b1;
      acmd_cnt_q  <= 8'd0;
      rsp_buf_q   <= 32'd0;
      rsp_left_q  <= 3'd0;
      go_data_q   <= 1'b0;
      dly_cnt_q   <= 8'd0;
      data_cnt_q  <= 9'd0;
      data_buf_q  <= 8'd0;
      crc_cnt_q   <= 1'b0;
      rreq_q      <= 1'b0;
      rreq_p_q    <= 1'b0;
      raddr_q     <= 32'd0;
      rindex_q    <= 9'd0;
`ifdef SD_RESPONDER_CRC16_EN
      crc_q       <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      frame_cnt_q <= frame_cnt_d;
      idx_sh_q    <= idx_sh_d;
      arg_sh_q    <= arg_sh_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      is_acmd_q   <= is_acmd_d;
      acmd_pend_q <= acmd_pend_d;
      in_idle_q   <= in_idle_d;
      acmd_cnt_q  <= acmd_cnt_d;
      rsp_buf_q   <= rsp_buf_d;
      rsp_left_q  <= rsp_left_d;
      go_data_q   <= go_data_d;
      dly_cnt_q   <= dly_cnt_d;
      data_cnt_q  <= data_cnt_d;
      data_buf_q  <= data_buf_d;
      crc_cnt_q   <= crc_cnt_d;
      rreq_q      <= rreq_d;
      rreq_p_q    <= rreq_p_d;
      raddr_q     <= raddr_d;
      rindex_q    <= rindex_d;
`ifdef SD_RESPONDER_CRC16_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.rreq      = rreq_q;
  assign bus.raddr     = raddr_q;
  assign bus.rindex    = rindex_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_index = cmd_index_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.in_idle   = in_idle_q;

endmodule
